// File: rtl/act_requant_stage_if.sv
// Stream bundle for the requant stage: 16-bit accumulator input side,
// 8-bit requantized output side with end-of-vector flag and sticky saturation.
interface act_requant_stage_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
);
    logic                    s_valid;
    logic                    s_ready;
    logic signed [IN_W-1:0]  data_in;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [OUT_W-1:0] data_out;
    logic                    m_last;
    logic                    sat_flag;

    modport master (
        output s_valid, data_in, m_ready,
        input  s_ready, m_valid, data_out, m_last, sat_flag
    );

    modport slave (
        input  s_valid, data_in, m_ready,
        output s_ready, m_valid, data_out, m_last, sat_flag
    );
endinterface

// File: rtl/act_requant_stage.sv
// Requantizes MAC results (ReLU, rounding shift, saturate to OUT_W) into a
// small FIFO and re-emits them as a vector stream tagged with m_last.
module act_requant_stage #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 4,
    parameter int DEPTH   = 4,
    parameter int VEC_LEN = 4,
    parameter int RELU_EN = 1
) (
    input logic                 clk,
    input logic                 reset,
    act_requant_stage_if.slave  bus
);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int EW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int RND = (2 ** SHIFT) / 2;
    localparam logic signed [IN_W:0] RND_V = (IN_W + 1)'(RND);
    localparam logic signed [IN_W:0] Q_MAX = (IN_W + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] Q_MIN = (IN_W + 1)'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {EMPTY = 2'd0, PART = 2'd1, FULL = 2'd2} occ_t;

    occ_t                    state, state_next;
    logic [CW-1:0]           count, count_next;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [EW-1:0]           elem;
    logic [OUT_W:0]          mem [DEPTH];
    logic                    ready_q, sat_q;
    logic                    push, pop, last_bit;
    logic signed [IN_W:0]    relu_v, round_v;
    logic signed [OUT_W-1:0] q_v;
    logic                    q_sat;

    assign push     = bus.s_valid && ready_q;
    assign pop      = bus.m_valid && bus.m_ready;
    assign last_bit = (elem == EW'(VEC_LEN - 1));

    assign bus.s_ready  = ready_q;
    assign bus.sat_flag = sat_q;
    assign bus.m_valid  = (state != EMPTY);
    assign bus.data_out = bus.m_valid ? mem[rd_ptr][OUT_W-1:0] : '0;
    assign bus.m_last   = bus.m_valid && mem[rd_ptr][OUT_W];

    // One extra bit of headroom so the rounding add never overflows.
    always_comb begin
        relu_v = {bus.data_in[IN_W-1], bus.data_in};
        if (RELU_EN != 0 && bus.data_in[IN_W-1])
            relu_v = '0;
        round_v = (relu_v + RND_V) >>> SHIFT;
        q_sat   = 1'b0;
        q_v     = round_v[OUT_W-1:0];
        if (round_v > Q_MAX) begin
            q_v   = Q_MAX[OUT_W-1:0];
            q_sat = 1'b1;
        end else if (round_v < Q_MIN) begin
            q_v   = Q_MIN[OUT_W-1:0];
            q_sat = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
        case (state)
            EMPTY: if (push) state_next = PART;
            PART: begin
                if (push && !pop && count == CW'(DEPTH - 1))
                    state_next = FULL;
                else if (pop && !push && count == CW'(1))
                    state_next = EMPTY;
            end
            FULL:  if (pop) state_next = PART;
            default: state_next = EMPTY;
        endcase
    end

    // s_ready is registered from the next occupancy so it never sees m_ready combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            elem    <= '0;
            ready_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            ready_q <= (count_next != CW'(DEPTH));
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                elem   <= last_bit ? '0 : elem + EW'(1);
                if (q_sat)
                    sat_q <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {last_bit, q_v};
    end
endmodule

// File: tb/tb_act_requant_stage.sv
// Drives two requant stages (ReLU on / off) with identical streams and checks
// both against a queue-based reference of the requantization rules.
module tb_act_requant_stage;
    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int SHIFT   = 4;
    localparam int DEPTH   = 4;
    localparam int VEC_LEN = 4;

    typedef struct {
        int data;
        bit last;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    ent_t q1[$];
    ent_t q0[$];
    bit   exp_ready = 1'b0;
    bit   exp_sat1 = 1'b0;
    bit   exp_sat0 = 1'b0;
    int   exp_elem = 0;

    act_requant_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b1 ();
    act_requant_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b0 ();

    act_requant_stage #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
        .DEPTH(DEPTH), .VEC_LEN(VEC_LEN), .RELU_EN(1)
    ) dut_relu (.clk(clk), .reset(reset), .bus(b1));

    act_requant_stage #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
        .DEPTH(DEPTH), .VEC_LEN(VEC_LEN), .RELU_EN(0)
    ) dut_lin (.clk(clk), .reset(reset), .bus(b0));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: floor((v + 2^(S-1)) / 2^S), then clamp to the signed OUT_W range.
    function automatic int requant(input int x, input bit relu, output bit sat);
        int v, num, div, q;
        v   = (relu && x < 0) ? 0 : x;
        div = 2 ** SHIFT;
        num = v + div / 2;
        q   = num / div;
        if (num < 0 && (num % div) != 0)
            q = q - 1;
        sat = 1'b0;
        if (q > 127) begin
            q = 127;
            sat = 1'b1;
        end else if (q < -128) begin
            q = -128;
            sat = 1'b1;
        end
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        ent_t h1, h0;
        bit   ne;
        ne = (q1.size() != 0);
        h1 = ne ? q1[0] : '{0, 1'b0};
        h0 = ne ? q0[0] : '{0, 1'b0};
        chk("relu_s_ready",  32'(b1.s_ready),  32'(exp_ready));
        chk("relu_m_valid",  32'(b1.m_valid),  32'(ne));
        chk("relu_data_out", {24'b0, b1.data_out}, {24'b0, 8'(h1.data)});
        chk("relu_m_last",   32'(b1.m_last),   32'(h1.last));
        chk("relu_sat_flag", 32'(b1.sat_flag), 32'(exp_sat1));
        chk("lin_s_ready",   32'(b0.s_ready),  32'(exp_ready));
        chk("lin_m_valid",   32'(b0.m_valid),  32'(ne));
        chk("lin_data_out",  {24'b0, b0.data_out}, {24'b0, 8'(h0.data)});
        chk("lin_m_last",    32'(b0.m_last),   32'(h0.last));
        chk("lin_sat_flag",  32'(b0.sat_flag), 32'(exp_sat0));
    endtask

    task automatic cycle(input bit sv, input int d, input bit mr, output bit acc);
        bit   pop, s1, s0;
        ent_t e1, e0;
        @(negedge clk);
        check_outputs();
        b1.s_valid = sv;  b1.data_in = 16'(d);  b1.m_ready = mr;
        b0.s_valid = sv;  b0.data_in = 16'(d);  b0.m_ready = mr;
        acc = sv && exp_ready;
        pop = (q1.size() != 0) && mr;
        @(posedge clk);
        if (pop) begin
            void'(q1.pop_front());
            void'(q0.pop_front());
        end
        if (acc) begin
            e1.data = requant(d, 1'b1, s1);
            e0.data = requant(d, 1'b0, s0);
            e1.last = (exp_elem == VEC_LEN - 1);
            e0.last = e1.last;
            q1.push_back(e1);
            q0.push_back(e0);
            exp_sat1 = exp_sat1 | s1;
            exp_sat0 = exp_sat0 | s0;
            exp_elem = (exp_elem + 1) % VEC_LEN;
        end
        exp_ready = (q1.size() != DEPTH);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b0, 0, 1'b1, acc);
    endtask

    task automatic release_reset();
        @(negedge clk);
        check_outputs();
        b1.s_valid = 1'b0;  b1.m_ready = 1'b0;  b1.data_in = '0;
        b0.s_valid = 1'b0;  b0.m_ready = 1'b0;  b0.data_in = '0;
        reset = 1'b1;
        @(posedge clk);
        exp_ready = 1'b1;
    endtask

    initial begin
        int  vec1 [4] = '{100, -50, 4000, 32767};
        int  vec2 [4] = '{-50, -4000, -32768, 7};
        int  seq  [12];
        int  idx;
        bit  acc;
        int  d;

        b1.s_valid = 1'b0;  b1.m_ready = 1'b0;  b1.data_in = '0;
        b0.s_valid = 1'b0;  b0.m_ready = 1'b0;  b0.data_in = '0;
        repeat (3) @(posedge clk);
        release_reset();

        // Directed vectors through both ReLU variants.
        for (int i = 0; i < 4; i++) cycle(1'b1, vec1[i], 1'b1, acc);
        drain();
        for (int i = 0; i < 4; i++) cycle(1'b1, vec2[i], 1'b1, acc);
        drain();

        // Back-pressure: fill to full with m_ready low, then release.
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(idx < 5, idx + 1, 1'b0, acc);
            if (acc) idx++;
        end
        for (int i = 0; i < 10 && idx < 5; i++) begin
            cycle(1'b1, idx + 1, 1'b1, acc);
            if (acc) idx++;
        end
        drain();

        // Continuous streaming, 12 random samples.
        for (int i = 0; i < 12; i++) seq[i] = int'($signed(16'($urandom)));
        idx = 0;
        for (int i = 0; i < 20 && idx < 12; i++) begin
            cycle(1'b1, seq[idx], 1'b1, acc);
            if (acc) idx++;
        end
        drain();

        // m_ready 1,0,0,1 while the head waits.
        cycle(1'b1, 300, 1'b1, acc);
        cycle(1'b1, -700, 1'b0, acc);
        cycle(1'b1, 2047, 1'b0, acc);
        cycle(1'b1, 9, 1'b1, acc);
        drain();

        // Random traffic including extreme values.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       d = 32767;
                1:       d = -32768;
                2:       d = int'($urandom_range(0, 40)) - 20;
                default: d = int'($signed(16'($urandom)));
            endcase
            cycle(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0), acc);
        end
        drain();

        // Reset mid-stream with three entries buffered.
        idx = 0;
        for (int i = 0; i < 8 && q1.size() < 3; i++)
            cycle(1'b1, 5000 + i, 1'b0, acc);
        cycle(1'b0, 0, 1'b0, acc);
        #3 reset = 1'b0;
        #1;
        chk("rst_relu_m_valid", 32'(b1.m_valid), 32'(0));
        chk("rst_relu_s_ready", 32'(b1.s_ready), 32'(0));
        chk("rst_lin_m_valid",  32'(b0.m_valid), 32'(0));
        chk("rst_lin_s_ready",  32'(b0.s_ready), 32'(0));
        q1.delete();
        q0.delete();
        exp_ready = 1'b0;
        exp_sat1  = 1'b0;
        exp_sat0  = 1'b0;
        exp_elem  = 0;
        release_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 16 * (i + 1), 1'b1, acc);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
